// File: rtl/supply_seq_pkg.sv
// Shared types for the LT1185 supply sequencer: FSM state encoding, which is
// also the status readback value, plus a small elaboration helper.
package supply_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF        = 3'd0,
        ST_WAIT_VIN   = 3'd1,
        ST_RAMP       = 3'd2,
        ST_ON         = 3'd3,
        ST_FAULT      = 3'd4,
        ST_RETRY_WAIT = 3'd5
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a debouncer: the output only follows the
// synchronized input after DEBOUNCE_CYCLES consecutive differing cycles.
module sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          db_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            // Any cycle that agrees with the current flag restarts the count.
            if (sync_q[1] == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                db_q  <= sync_q[1];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign dout = db_q;

endmodule

// File: rtl/supply_sequencer.sv
// Enable/supervisor FSM for the LT1185 5 V regulator: debounced VIN/VOUT
// monitoring, ramp timeout, optional bounded retry (SUPPLY_SEQ_RETRY_EN).
//
// state      | meaning
// OFF        | rail off, idle
// WAIT_VIN   | rail requested, waiting for regulator input supply
// RAMP       | regulator enabled, waiting for VOUT inside window
// ON         | rail up and stable, power good
// FAULT      | regulator off, fault reported
// RETRY_WAIT | regulator off, timing the off-period before a retry
module supply_sequencer
    import supply_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RAMP_TIMEOUT    = 1024,
    parameter int RETRY_DELAY     = 4096,
    parameter int MAX_RETRIES     = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_req,
    input  logic                vin_ok,
    input  logic                vout_ok,
    input  logic                fault_clr,
    output logic                reg_en,
    output logic                pwr_good,
    output logic                fault,
    output logic [STATE_W-1:0]  state,
    output logic [1:0]          retry_cnt
);

    localparam int TIMER_TOP = max_int(RAMP_TIMEOUT, RETRY_DELAY);
    localparam int TW        = (TIMER_TOP > 2) ? $clog2(TIMER_TOP) : 1;

    localparam logic [TW-1:0] TIMER_MAX   = '1;
    localparam logic [TW-1:0] RAMP_LAST   = TW'(RAMP_TIMEOUT - 1);
    localparam logic [1:0]    RETRY_LIMIT = 2'(MAX_RETRIES);
`ifdef SUPPLY_SEQ_RETRY_EN
    localparam logic [TW-1:0] RETRY_LAST  = TW'(RETRY_DELAY - 1);
`endif

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] timer_q;
    logic [1:0]    retry_q;
    logic          retry_inc;
    logic          retry_clr;
    logic          vin_db;
    logic          vout_db;

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_vin_db (
        .clk   (clk),
        .reset (reset),
        .din   (vin_ok),
        .dout  (vin_db)
    );

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_vout_db (
        .clk   (clk),
        .reset (reset),
        .din   (vout_ok),
        .dout  (vout_db)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority: fault_clr, then enable_req low, then fault/timeout, then progress.
    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (enable_req) begin
                    state_d = ST_WAIT_VIN;
                end
            end
            ST_WAIT_VIN: begin
                if (!enable_req) begin
                    state_d = ST_OFF;
                end else if (vin_db) begin
                    state_d = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (!enable_req) begin
                    state_d = ST_OFF;
                end else if (timer_q == RAMP_LAST) begin
                    state_d = ST_FAULT;
                end else if (vout_db) begin
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
                if (!enable_req) begin
                    state_d = ST_OFF;
                end else if (!vin_db || !vout_db) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d   = ST_OFF;
                    retry_clr = 1'b1;
                end
`ifdef SUPPLY_SEQ_RETRY_EN
                else if (retry_q < RETRY_LIMIT) begin
                    state_d = ST_RETRY_WAIT;
                end
`endif
            end
            ST_RETRY_WAIT: begin
`ifdef SUPPLY_SEQ_RETRY_EN
                if (fault_clr) begin
                    state_d   = ST_OFF;
                    retry_clr = 1'b1;
                end else if (timer_q == RETRY_LAST) begin
                    state_d   = ST_WAIT_VIN;
                    retry_inc = 1'b1;
                end
`else
                state_d = ST_FAULT;
`endif
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // Shared timer: restarts on every state change and holds at full scale.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else if (state_d != state_q) begin
            timer_q <= '0;
        end else if (timer_q != TIMER_MAX) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || retry_clr) begin
            retry_q <= 2'b00;
        end else if (retry_inc && (retry_q != RETRY_LIMIT)) begin
            retry_q <= retry_q + 1'b1;
        end
    end

    always_comb begin
        reg_en   = 1'b0;
        pwr_good = 1'b0;
        fault    = 1'b0;
        case (state_q)
            ST_RAMP: begin
                reg_en = 1'b1;
            end
            ST_ON: begin
                reg_en   = 1'b1;
                pwr_good = 1'b1;
            end
            ST_FAULT, ST_RETRY_WAIT: begin
                fault = 1'b1;
            end
            default: begin
                reg_en = 1'b0;
            end
        endcase
    end

    assign state     = state_q;
    assign retry_cnt = retry_q;

endmodule

// File: doc/supply_sequencer.md
# supply_sequencer

Digital enable/supervisor stage directly upstream of the LT1185 5 V regulator. It drives the regulator enable, watches the analog comparator flags derived from VIN and from VOUT versus REF, and reports power-good or fault to board control logic. It debounces the asynchronous comparator inputs, enforces a ramp timeout, and on fault shuts the regulator off, optionally retrying a bounded number of times.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required before a debounced flag changes (≥2).
- `RAMP_TIMEOUT`, 1024: maximum cycles in RAMP before declaring a fault.
- `RETRY_DELAY`, 4096: off-time in cycles before a retry (retry build only).
- `MAX_RETRIES`, 3: retries before the fault latches (retry build only, 1..3).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `enable_req`  in  1  request that the 5 V rail be on; synchronous to `clk`.
- `vin_ok`  in  1  asynchronous comparator: regulator input above threshold.
- `vout_ok`  in  1  asynchronous comparator: VOUT within window of REF.
- `fault_clr`  in  1  single-cycle pulse that clears a latched fault.
- `reg_en`  out  1  regulator enable.
- `pwr_good`  out  1  rail is up and stable.
- `fault`  out  1  fault indication.
- `state`  out  3  current state encoding, for status readback.
- `retry_cnt`  out  2  retries consumed since the last clear.

## Operation
- `vin_ok` and `vout_ok` each pass through a 2-flop synchronizer and then a debouncer. The debounced flag takes the synchronized value only after it has differed from the current flag for `DEBOUNCE_CYCLES` consecutive cycles; any bounce restarts the count.
- States: OFF=0, WAIT_VIN=1, RAMP=2, ON=3, FAULT=4, RETRY_WAIT=5. Codes 6 and 7 are illegal and go to FAULT.
- OFF: when `enable_req`=1, go to WAIT_VIN.
- WAIT_VIN: when `vin_db`=1, go to RAMP and clear the timer. When `enable_req`=0, go to OFF.
- RAMP: when `vout_db`=1, go to ON. When the timer reaches `RAMP_TIMEOUT`-1, go to FAULT. When `enable_req`=0, go to OFF.
- ON: when `vout_db`=0 or `vin_db`=0, go to FAULT. When `enable_req`=0, go to OFF.
- FAULT: `fault_clr`=1 moves to OFF and clears `retry_cnt`. `enable_req` is ignored.
- RETRY_WAIT: runs the timer to `RETRY_DELAY`-1, then moves to WAIT_VIN and increments `retry_cnt`. `fault_clr` moves to OFF and clears `retry_cnt`.
- Outputs are a Moore decode of the state register:
  - `reg_en`=1 in RAMP and ON only.
  - `pwr_good`=1 in ON only.
  - `fault`=1 in FAULT and RETRY_WAIT.
- Priority when events coincide in one cycle: `reset` > `fault_clr` > `enable_req`=0 > fault or timeout > progress. A falling `enable_req` together with a `vout` drop in ON goes to OFF with no fault.
- Timer: one shared counter, width `$clog2(max(RAMP_TIMEOUT,RETRY_DELAY))`. It clears on every state change and saturates. `retry_cnt` saturates at `MAX_RETRIES`.

## Timing
- Reset, from the first edge with `reset`=1:
  - state=OFF, so `reg_en`=0, `pwr_good`=0, `fault`=0, `retry_cnt`=0.
  - Timer, synchronizers, and debounced flags clear to 0.
- Latency from an `enable_req` rise to `reg_en` rise is 2 cycles when `vin_db` is already 1.
- Latency from a `vout_ok` edge to `vout_db` is 2 + `DEBOUNCE_CYCLES` cycles.
- `pwr_good` rises 1 cycle after `vout_db` rises while in RAMP.
- A fault drops `reg_en` and `pwr_good` in the cycle after detection.
- `reset` asserted mid-ramp drops `reg_en` on the next edge. No state survives reset.

## Configuration
- `SUPPLY_SEQ_RETRY_EN` defined:
  - FAULT moves to RETRY_WAIT on the next cycle when `retry_cnt` < `MAX_RETRIES`.
  - Otherwise FAULT holds until `fault_clr`.
- `SUPPLY_SEQ_RETRY_EN` undefined:
  - FAULT always holds until `fault_clr`.
  - RETRY_WAIT is unreachable and `retry_cnt` stays 0.
  - The `RETRY_DELAY` and `MAX_RETRIES` parameters are ignored.

## Structure
- Package `supply_seq_pkg` holds the state enum with its fixed encodings and the state-width constant.
- Sub-module `sync_debounce` contains the 2-flop synchronizer plus the debounce counter, parameterized by `DEBOUNCE_CYCLES`. It is instantiated twice, once for `vin_ok` and once for `vout_ok`.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `RAMP_TIMEOUT`=32, `RETRY_DELAY`=64, `MAX_RETRIES`=2.
- **Normal power-up.** Apply `vin_ok`=1 for 10 cycles, then `enable_req`=1, then `vout_ok`=1 at cycle +10 → `reg_en` high 2 cycles after `enable_req`; `pwr_good` high 7 cycles after `vout_ok`; `fault`=0 throughout.
- **Debounce.** Pulse `vout_ok` high for 3 cycles during RAMP → no transition to ON; `pwr_good` stays 0.
- **Ramp timeout, retry build.** Hold `vout_ok`=0 → FAULT 32 cycles after RAMP entry; RETRY_WAIT lasts 64 cycles; after 2 retries `fault` holds and `retry_cnt`=2; `fault_clr` → OFF with `retry_cnt`=0.
- **Ramp timeout, non-retry build.** Same stimulus → FAULT latched; `reg_en`=0 indefinitely until `fault_clr`.
- **Brown-out and coincident events.** In ON, drop `vin_ok` → `fault` rises 7 cycles later. In a separate run, drop `enable_req` and `vout_ok` in the same cycle → OFF, `fault`=0.
- **Reset mid-ramp.** Assert `reset` while in RAMP → next edge gives `reg_en`=0, state=0, all outputs at their reset values.
